// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   mult_state_e   : controller state encoding (IDLE / RUN / DONE)
//   MULT_N_DEFAULT : default operand width in bits
package mult_pkg;

  localparam int MULT_N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage : mult_pkg

// File: rtl/cond_negate.sv
// Conditional two's-complement negation.
//   en   : when 1, dout = -din (mod 2^W); when 0, dout = din
//   din  : W-bit input value
//   dout : W-bit result
// The most-negative value maps to itself, which read as unsigned is its magnitude.
module cond_negate #(
  parameter int W = 4
) (
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  always_comb begin
    dout = din;
    if (en) dout = ~din + W'(1);
  end

endmodule : cond_negate

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per clock.
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset
//   start   : begin a multiply (sampled only in IDLE)
//   a, b    : N-bit multiplicand / multiplier, captured on the accepting edge
//   busy    : high while in RUN or DONE
//   done    : one-cycle pulse, product holds the new result
//   product : 2N-bit result register, held between completions
// Latency is N+1 edges from accept to done; all outputs are registered.
//
// state | meaning
// IDLE  | waiting for start, product held
// RUN   | one shift-add step per cycle, N cycles
// DONE  | done pulse cycle, returns to IDLE unconditionally
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int N           = MULT_N_DEFAULT,
  parameter bit SIGNED_MODE = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int IW = $clog2(N);

  mult_state_e    state_q, state_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] product_q, product_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [IW-1:0]  iter_q, iter_d;
  logic           neg_q, neg_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;

  logic [N-1:0]   mag_a, mag_b;
  logic [2*N-1:0] acc_sum, result;

  // Operands enter the datapath as magnitudes; sign is folded back in at the end.
  cond_negate #(.W(N)) u_abs_a (
    .en   (SIGNED_MODE && a[N-1]),
    .din  (a),
    .dout (mag_a)
  );

  cond_negate #(.W(N)) u_abs_b (
    .en   (SIGNED_MODE && b[N-1]),
    .din  (b),
    .dout (mag_b)
  );

  // Accumulator after this cycle's step; also the final magnitude on the last step.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  cond_negate #(.W(2*N)) u_neg_res (
    .en   (neg_q),
    .din  (acc_sum),
    .dout (result)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    product_d = product_q;
    mplier_d  = mplier_q;
    iter_d    = iter_q;
    neg_d     = neg_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{N{1'b0}}, mag_a};
          mplier_d = mag_b;
          acc_d    = '0;
          iter_d   = '0;
          neg_d    = SIGNED_MODE && (a[N-1] ^ b[N-1]);
          state_d  = RUN;
        end
      end
      RUN: begin
        // mcand_q is kept pre-shifted, so it always equals multiplicand << iter_q.
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        iter_d   = iter_q + IW'(1);
        if (iter_q == IW'(N - 1)) begin
          product_d = result;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      mplier_q  <= '0;
      iter_q    <= '0;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      mplier_q  <= mplier_d;
      iter_q    <= iter_d;
      neg_q     <= neg_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  start_v = '0;
  logic [15:0] a_w = '0;
  logic [15:0] b_w = '0;
  wire  [5:0]  done_v;
  wire  [5:0]  busy_v;
  wire  [7:0]  p0, p1;
  wire  [15:0] p2, p3;
  wire  [31:0] p4, p5;
  logic [31:0] prod_v [6];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Instances: 0=N4 unsigned, 1=N4 signed, 2=N8 u, 3=N8 s, 4=N16 u, 5=N16 s
  seq_multiplier #(.N(4), .SIGNED_MODE(1'b0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_w[3:0]), .b(b_w[3:0]),
    .busy(busy_v[0]), .done(done_v[0]), .product(p0));
  seq_multiplier #(.N(4), .SIGNED_MODE(1'b1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_w[3:0]), .b(b_w[3:0]),
    .busy(busy_v[1]), .done(done_v[1]), .product(p1));
  seq_multiplier #(.N(8), .SIGNED_MODE(1'b0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_w[7:0]), .b(b_w[7:0]),
    .busy(busy_v[2]), .done(done_v[2]), .product(p2));
  seq_multiplier #(.N(8), .SIGNED_MODE(1'b1)) u_d3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a(a_w[7:0]), .b(b_w[7:0]),
    .busy(busy_v[3]), .done(done_v[3]), .product(p3));
  seq_multiplier #(.N(16), .SIGNED_MODE(1'b0)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[4]), .a(a_w), .b(b_w),
    .busy(busy_v[4]), .done(done_v[4]), .product(p4));
  seq_multiplier #(.N(16), .SIGNED_MODE(1'b1)) u_d5 (
    .clk(clk), .rst_n(rst_n), .start(start_v[5]), .a(a_w), .b(b_w),
    .busy(busy_v[5]), .done(done_v[5]), .product(p5));

  assign prod_v[0] = {24'd0, p0};
  assign prod_v[1] = {24'd0, p1};
  assign prod_v[2] = {16'd0, p2};
  assign prod_v[3] = {16'd0, p3};
  assign prod_v[4] = p4;
  assign prod_v[5] = p5;

  function automatic int n_of(input int idx);
    case (idx)
      0, 1:    return 4;
      2, 3:    return 8;
      default: return 16;
    endcase
  endfunction

  function automatic bit sgn_of(input int idx);
    return (idx % 2) == 1;
  endfunction

  // Reference: interpret operands as plain integers, multiply, keep 2N bits.
  function automatic logic [31:0] ref_mul(input int n, input bit sgn,
                                          input logic [15:0] av, input logic [15:0] bv);
    longint x, y, p, opmask, resmask;
    opmask  = (longint'(1) << n) - 1;
    resmask = (longint'(1) << (2 * n)) - 1;
    x = longint'(av) & opmask;
    y = longint'(bv) & opmask;
    if (sgn && av[n-1]) x = x - (longint'(1) << n);
    if (sgn && bv[n-1]) y = y - (longint'(1) << n);
    p = x * y;
    return 32'(p & resmask);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Called at the negedge before the accepting edge (start already driven).
  task automatic finish_op(input int idx, input logic [31:0] exp, input string nm);
    int  n;
    int  cyc;
    int  busy_cnt;
    bit  got;
    n = n_of(idx);
    busy_cnt = 0;
    got = 1'b0;
    cyc = 1;
    @(negedge clk);
    start_v[idx] = 1'b0;
    while (cyc <= 3 * n + 8) begin
      if (busy_v[idx]) busy_cnt++;
      if (done_v[idx]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles, expected at %0d", nm, cyc, n + 1);
    end else begin
      check({nm, "_lat"}, 64'(cyc), 64'(n + 1));
      check({nm, "_prod"}, 64'(prod_v[idx]), 64'(exp));
      @(negedge clk);
      check({nm, "_pulse"}, 64'(done_v[idx]), 64'd0);
      check({nm, "_busy_end"}, 64'(busy_v[idx]), 64'd0);
      check({nm, "_busy_cnt"}, 64'(busy_cnt), 64'(n + 1));
      check({nm, "_held"}, 64'(prod_v[idx]), 64'(exp));
    end
  endtask

  task automatic run_op(input int idx, input logic [15:0] av, input logic [15:0] bv,
                        input logic [31:0] exp, input string nm);
    @(negedge clk);
    a_w = av;
    b_w = bv;
    start_v[idx] = 1'b1;
    finish_op(idx, exp, nm);
  endtask

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int          t_done [2];
    logic [31:0] p_done [2];
    int          nd;
    logic [15:0] ra, rb;

    tbl.push_back('{0, 16'd15,    16'd15,    32'd225});
    tbl.push_back('{0, 16'd0,     16'd9,     32'd0});
    tbl.push_back('{0, 16'd1,     16'd15,    32'd15});
    tbl.push_back('{1, 16'h8,     16'h8,     32'd64});
    tbl.push_back('{1, 16'h8,     16'd7,     32'hC8});
    tbl.push_back('{1, 16'd7,     16'h8,     32'hC8});
    tbl.push_back('{1, 16'hF,     16'hF,     32'd1});
    tbl.push_back('{1, 16'd7,     16'd7,     32'd49});
    tbl.push_back('{1, 16'd0,     16'h8,     32'd0});
    tbl.push_back('{2, 16'd255,   16'd255,   32'hFE01});
    tbl.push_back('{3, 16'h80,    16'h80,    32'h4000});
    tbl.push_back('{3, 16'h80,    16'h7F,    32'hC080});
    tbl.push_back('{4, 16'hFFFF,  16'hFFFF,  32'hFFFE0001});
    tbl.push_back('{5, 16'h8000,  16'h8000,  32'h40000000});
    tbl.push_back('{5, 16'h8000,  16'h0001,  32'hFFFF8000});
    tbl.push_back('{5, 16'hFFFF,  16'h0002,  32'hFFFFFFFE});

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      check("rst_busy", 64'(busy_v[i]), 64'd0);
      check("rst_done", 64'(done_v[i]), 64'd0);
      check("rst_prod", 64'(prod_v[i]), 64'd0);
    end

    // Directed table
    for (int i = 0; i < tbl.size(); i++)
      run_op(tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("tbl%0d", i));

    // Start held high: two back-to-back results, operand change mid-RUN ignored
    @(negedge clk);
    a_w = 16'd3;
    b_w = 16'd5;
    start_v[0] = 1'b1;
    nd = 0;
    for (int c = 1; c <= 30 && nd < 2; c++) begin
      @(negedge clk);
      if (c == 2) begin
        a_w = 16'd2;
        b_w = 16'd2;
      end
      if (done_v[0]) begin
        t_done[nd] = c;
        p_done[nd] = prod_v[0];
        nd++;
      end
    end
    start_v[0] = 1'b0;
    check("held_count", 64'(nd), 64'd2);
    if (nd == 2) begin
      check("held_lat1", 64'(t_done[0]), 64'd5);
      check("held_prod1", 64'(p_done[0]), 64'd15);
      check("held_prod2", 64'(p_done[1]), 64'd4);
      check("held_gap", 64'(t_done[1] - t_done[0]), 64'd6);
    end
    repeat (6) @(negedge clk);
    check("idle_hold_busy", 64'(busy_v[0]), 64'd0);
    check("idle_hold_prod", 64'(prod_v[0]), 64'd4);

    // Reset mid-RUN with start asserted, then start on the first released edge
    a_w = 16'd9;
    b_w = 16'd9;
    start_v[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 64'(busy_v[0]), 64'd0);
    check("rst_mid_done", 64'(done_v[0]), 64'd0);
    check("rst_mid_prod", 64'(prod_v[0]), 64'd0);
    rst_n = 1'b1;
    a_w = 16'd6;
    b_w = 16'd7;
    finish_op(0, 32'd42, "post_rst");

    // Exhaustive N=4 sweep, both modes
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        run_op(0, 16'(i), 16'(j), ref_mul(4, 1'b0, 16'(i), 16'(j)), "sweep4u");
        run_op(1, 16'(i), 16'(j), ref_mul(4, 1'b1, 16'(i), 16'(j)), "sweep4s");
      end

    // Random sweeps at N=8 and N=16
    for (int k = 0; k < 120; k++) begin
      for (int idx = 2; idx < 6; idx++) begin
        ra = 16'($urandom_range(0, 65535));
        rb = 16'($urandom_range(0, 65535));
        if (n_of(idx) == 8) begin
          ra[15:8] = 8'd0;
          rb[15:8] = 8'd0;
        end
        run_op(idx, ra, rb, ref_mul(n_of(idx), sgn_of(idx), ra, rb),
               $sformatf("rand_i%0d", idx));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_seq_multiplier

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter N, default 4, meaning operand width in bits; legal range 2..32.
REQ-002 SHALL have parameter SIGNED_MODE, default 0, meaning 0 = unsigned operands, 1 = two's-complement operands.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-006 SHALL have port a  input  N  multiplicand; captured on the accepting edge.
REQ-007 SHALL have port b  input  N  multiplier; captured on the accepting edge.
REQ-008 SHALL have port busy  output  1  high while in RUN or DONE.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking product valid for the new result.
REQ-010 SHALL have port product  output  2N  result register, held between completions.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 SHALL, in IDLE with start=1 at an edge, capture a and b, clear accumulator, load iteration count 0, and enter RUN.
REQ-013 SHALL, in IDLE with start=0, remain in IDLE with no register change.
REQ-014 SHALL perform one shift-add iteration per RUN cycle: if current multiplier LSB=1, add multiplicand (zero-extended to 2N) shifted by iteration index into the accumulator; then shift multiplier right by 1.
REQ-015 SHALL stay in RUN exactly N cycles; on the Nth RUN edge, write the final result to product, set done=1, and enter DONE.
REQ-016 SHALL make done high for exactly the one cycle following the edge N+1 edges after the accepting edge, i.e. latency N+1 cycles from start accept to done.
REQ-017 SHALL return from DONE to IDLE on the next edge unconditionally, with done=0.
REQ-018 SHALL ignore start in RUN and DONE: no recapture, no restart, no latency change.
REQ-019 SHALL allow back-to-back operation: start high in the first IDLE cycle after DONE is accepted at that edge.
REQ-020 SHALL, with SIGNED_MODE=1, multiply operand magnitudes as unsigned N-bit values and two's-complement negate the 2N-bit result when operand signs differ.
REQ-021 SHALL treat -2^(N-1) as magnitude 2^(N-1) in N-bit unsigned form; the 2N-bit result never overflows for any operand pair.
REQ-022 SHALL, with SIGNED_MODE=0, produce the exact unsigned 2N-bit product.
REQ-023 SHALL hold product unchanged at all times except the completion edge and reset.
REQ-024 SHALL treat a zero operand like any other: full N-cycle latency, no early termination.

Reset
REQ-025 SHALL, on any edge with rst_n=0, force state IDLE, busy=0, done=0, product=0, and clear all internal registers.
REQ-026 SHALL abort an in-flight operation on reset mid-RUN or mid-DONE; no done pulse is issued for it.
REQ-027 SHALL give rst_n priority over start at the same edge.
REQ-028 SHALL accept start on the first edge where rst_n=1.

Structure
REQ-029 SHALL take the FSM state type and the default operand width from the shared package mult_pkg.
REQ-030 SHALL instantiate one sub-module cond_negate (width parameter, enable input) used for operand magnitude extraction and result negation; with SIGNED_MODE=0 its enable is tied low.
REQ-031 SHALL register every output directly; no combinational path from inputs to outputs.

Verification
REQ-032 SHALL verify N=4, unsigned: a=15, b=15, start one cycle -> done after 5 cycles, product=8'd225, busy high exactly 5 cycles.
REQ-033 SHALL verify N=4, signed: a=4'b1000, b=4'b1000 -> product=8'd64; a=4'b1000, b=4'd7 -> product=8'hC8 (-56).
REQ-034 SHALL verify start held high continuously with N=4: a=3,b=5 then a=2,b=2 -> two results, 15 then 4, done pulses 6 cycles apart, and operand changes mid-RUN have no effect.
REQ-035 SHALL verify reset mid-RUN: rst_n=0 at RUN cycle 2 -> product=0, done never pulses, next start a=6,b=7 -> product=42.
REQ-036 SHALL verify exhaustive operand sweep at N=4 in both modes against a reference model, plus random sweep at N=8 and N=16.
